// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, FSM state type and default branch-target table
//                for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 9;
   localparam int LUT_AW  = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Default targets are spaced 32 words apart; real programs override LUT_INIT.
   function automatic logic [(2**LUT_AW)*PC_W-1:0] lut_default();
      logic [(2**LUT_AW)*PC_W-1:0] v;
      v = '0;
      for (int i = 0; i < 2**LUT_AW; i++) begin
         v[i*PC_W +: PC_W] = PC_W'(i * 32);
      end
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
//  Module      : branch_lut
//  Description : Constant branch-target table, read combinationally by index.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_lut #(
   parameter int PC_W   = fetch_pkg::PC_W,
   parameter int LUT_AW = fetch_pkg::LUT_AW,
   parameter logic [(2**LUT_AW)*PC_W-1:0] LUT_INIT = fetch_pkg::lut_default()
) (
   input  logic [LUT_AW-1:0] i_addr,
   output logic [PC_W-1:0]   o_target
);

   logic [PC_W-1:0] w_table [2**LUT_AW];

   for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_entry
      assign w_table[gi] = LUT_INIT[gi*PC_W +: PC_W];
   end

   assign o_target = w_table[i_addr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : PC sequencer and fetch stage over a synchronous-read ROM with
//                LUT-based branch redirect, halt, and Start/Done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter int PC_W    = fetch_pkg::PC_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W,
   parameter int LUT_AW  = fetch_pkg::LUT_AW,
   parameter logic [(2**LUT_AW)*PC_W-1:0] LUT_INIT = fetch_pkg::lut_default()
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   output logic               Done,
   output logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [PC_W-1:0]    instr_pc,
   input  logic               Branch,
   input  logic               BranchTaken,
   input  logic               Halt
);

   import fetch_pkg::*;

   fetch_state_t    r_state;
   fetch_state_t    w_next_state;

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_instr_pc;
   logic            r_fetched;
   logic            r_squash;

   logic            w_live;
   logic            w_halt;
   logic            w_taken;
   logic            w_advance;
   logic            w_restart;
   logic            w_done;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_next_pc;

   branch_lut #(
      .PC_W     (PC_W),
      .LUT_AW   (LUT_AW),
      .LUT_INIT (LUT_INIT)
   ) u_lut (
      .i_addr   (prog_data[LUT_AW-1:0]),
      .o_target (w_target)
   );

   // A word is live only if it was fetched in RUN and not the slot behind a taken branch.
   assign w_live  = r_fetched & ~r_squash;
   assign w_halt  = Halt & w_live;
   assign w_taken = Branch & BranchTaken & w_live & ~Halt;

   assign w_next_pc = w_taken ? w_target : r_pc + 1'b1;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (Start)  w_next_state = RUN;
         RUN:     if (w_halt) w_next_state = HALTED;
         HALTED:  if (Start)  w_next_state = RUN;
         default:             w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_done    = 1'b0;
      w_advance = 1'b0;
      w_restart = 1'b0;
      case (r_state)
         IDLE:    w_restart = Start;
         RUN:     w_advance = ~w_halt;
         HALTED: begin
            w_done    = 1'b1;
            w_restart = Start;
         end
         default: w_done = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pc       <= '0;
         r_instr_pc <= '0;
         r_fetched  <= 1'b0;
         r_squash   <= 1'b0;
      end else if (w_restart) begin
         r_pc      <= '0;
         r_fetched <= 1'b0;
         r_squash  <= 1'b0;
      end else if (w_advance) begin
         r_instr_pc <= r_pc;
         r_pc       <= w_next_pc;
         r_fetched  <= 1'b1;
         r_squash   <= w_taken;
      end else begin
         r_fetched <= 1'b0;
         r_squash  <= 1'b0;
      end
   end

   assign Done        = w_done;
   assign prog_addr   = r_pc;
   assign instr       = prog_data;
   assign instr_valid = w_live;
   assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch with ROM, decoder stub and
//                cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam int PCW = 10;
   localparam int NL  = 32;

   localparam logic [3:0] OP_BNE  = 4'h8;
   localparam logic [3:0] OP_BOTH = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic [PCW-1:0] lut_ref(input int idx);
      if (idx == 3) return 10'h020;
      if (idx == 7) return 10'h3FE;
      return PCW'((idx * 37 + 11) % 1024);
   endfunction

   function automatic logic [NL*PCW-1:0] make_lut();
      logic [NL*PCW-1:0] v;
      v = '0;
      for (int i = 0; i < NL; i++) v[i*PCW +: PCW] = lut_ref(i);
      return v;
   endfunction

   localparam logic [NL*PCW-1:0] LUT_VALS = make_lut();

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           done;
   logic [PCW-1:0] prog_addr;
   logic [8:0]     prog_data;
   logic [8:0]     instr;
   logic           instr_valid;
   logic [PCW-1:0] instr_pc;
   logic           branch;
   logic           branch_taken;
   logic           halt;
   logic           tk;

   logic [8:0]     mem [1024];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int             m_mode;   // 0 idle, 1 run, 2 halted
   logic [PCW-1:0] m_pc;
   logic [PCW-1:0] m_slot;
   bit             m_live;

   always #5 clk = ~clk;

   always @(posedge clk) prog_data <= mem[prog_addr];

   // decoder stub: decodes whatever word is presented, valid or not
   assign halt         = (instr[8:5] == OP_HALT) || (instr[8:5] == OP_BOTH);
   assign branch       = (instr[8:5] == OP_BNE)  || (instr[8:5] == OP_BOTH);
   assign branch_taken = tk;

   instr_fetch #(
      .PC_W     (PCW),
      .INSTR_W  (9),
      .LUT_AW   (5),
      .LUT_INIT (LUT_VALS)
   ) dut (
      .Clk         (clk),
      .Reset       (rst),
      .Start       (start),
      .Done        (done),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .Branch      (branch),
      .BranchTaken (branch_taken),
      .Halt        (halt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] plain_word();
      logic [3:0] op;
      op = 4'($urandom_range(0, 11));
      if (op > 4'd7) op = op + 4'd2;
      return {op, 5'($urandom_range(0, 31))};
   endfunction

   task automatic fill_plain();
      for (int i = 0; i < 1024; i++) mem[i] = plain_word();
   endtask

   task automatic model_reset();
      m_mode = 0; m_pc = '0; m_slot = '0; m_live = 1'b0;
   endtask

   task automatic model_edge(input bit st, input bit taken_in);
      logic [8:0] w;
      bit         h, b;
      w = mem[m_slot];
      case (m_mode)
         1: begin
            h = m_live && (w[8:5] == OP_HALT || w[8:5] == OP_BOTH);
            b = m_live && (w[8:5] == OP_BNE  || w[8:5] == OP_BOTH) && taken_in;
            if (h) begin
               m_mode = 2; m_live = 1'b0;
            end else begin
               m_slot = m_pc;
               if (b) begin
                  m_pc = lut_ref(int'(w[4:0])); m_live = 1'b0;
               end else begin
                  m_pc = m_pc + 1'b1; m_live = 1'b1;
               end
            end
         end
         default: if (st) begin m_mode = 1; m_pc = '0; m_live = 1'b0; end
      endcase
   endtask

   task automatic check_all();
      chk("prog_addr",   32'(prog_addr),   32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_live));
      chk("instr_pc",    32'(instr_pc),    32'(m_slot));
      chk("done",        32'(done),        32'(m_mode == 2));
      if (m_live) chk("instr", 32'(instr), 32'(mem[m_slot]));
   endtask

   task automatic cycle(input bit st);
      start = st;
      @(posedge clk);
      model_edge(st, tk);
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0);
   endtask

   initial begin
      int guard;
      rst = 1'b1; start = 1'b0; tk = 1'b0;
      fill_plain();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // straight-line program ending in halt
      mem[0] = {4'h1, 5'd4}; mem[1] = {4'h2, 5'd9}; mem[2] = {4'h3, 5'd1}; mem[3] = {OP_HALT, 5'd0};
      cycle(1'b1);
      chk("first_valid_low", 32'(instr_valid), 32'd0);
      run(8);
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_pc_frozen", 32'(prog_addr), 32'd4);
      // restart from HALTED
      cycle(1'b1);
      chk("restart_done_low", 32'(done), 32'd0);
      chk("restart_addr", 32'(prog_addr), 32'd0);
      run(8);

      // taken branch at pc 5 through lut[3]
      fill_plain();
      mem[5] = {OP_BNE, 5'd3}; mem[10'h24] = {OP_HALT, 5'd0};
      tk = 1'b1;
      cycle(1'b1);
      run(20);

      // not-taken branch
      fill_plain();
      mem[5] = {OP_BNE, 5'd3}; mem[9] = {OP_HALT, 5'd0};
      tk = 1'b0;
      cycle(1'b1);
      run(15);

      // halt and branch in the same word
      fill_plain();
      mem[5] = {OP_BOTH, 5'd3};
      tk = 1'b1;
      cycle(1'b1);
      run(10);
      chk("both_done", 32'(done), 32'd1);
      chk("both_no_redirect", 32'(prog_addr), 32'd6);

      // wrap 0x3FF -> 0x000, then reset mid-run at pc 7
      fill_plain();
      mem[0] = {OP_BNE, 5'd7};
      tk = 1'b1;
      cycle(1'b1);
      run(5);
      tk = 1'b0;
      guard = 0;
      while (!(m_mode == 1 && m_pc == 10'd7) && guard < 40) begin
         cycle(1'b0);
         guard++;
      end
      chk("reach_pc7_timeout", 32'(guard < 40), 32'd1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1 rst = 1'b0;
      run(3);

      // randomized programs, decisions and restarts
      for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 511));
      for (int i = 0; i < 400; i++) begin
         tk = 1'($urandom_range(0, 1));
         cycle(($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
